vector_norm_sqrt: RTL and testbench
===================================

// Module: vector_norm_sqrt
// PURPOSE
//  Downstream consumer of the 4-input multiply/adder-tree result (sum of squares A^2+B^2+C^2+D^2).
//  Computes the vector magnitude as the floor integer square root of that sum, with the remainder.
//  Fully pipelined digit-by-digit (restoring) square root, one root bit resolved per stage.
//  Accepts one input per cycle. Valid/ready on the output; stalls propagate back to i_ready.
// PARAMETERS
//  DATAWIDTH    4   element width of the upstream multipliers; radicand IN_W = 2*DATAWIDTH+2
//  INSTANCE_ID  0   instance tag, carried for debug/synthesis reports only
//  (localparam) ROOT_W = DATAWIDTH+1   root width, equal to the pipeline depth
//  (localparam) REM_W  = DATAWIDTH+2   remainder width (rem <= 2*root)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-LOW (asserted when 0)
//  i_valid   in   1       radicand valid
//  i_data    in   IN_W    radicand, unsigned
//  i_ready   out  1       stage can accept i_data this cycle
//  o_valid   out  1       result valid
//  o_ready   in   1       downstream accepts result
//  o_root    out  ROOT_W  floor(sqrt(i_data)); rounded when VECTOR_NORM_ROUND_EN is defined
//  o_rem     out  REM_W   i_data - floor_root^2 (always of the floor root)
//  o_overflow out 1       sticky: input offered while i_ready=0
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids, o_valid, o_root, o_rem and o_overflow go to 0 immediately.
//    In-flight data is discarded. First capture is on the first rising edge after rst=1.
//  - Stage k (k=0..ROOT_W-1, MSB first):
//    rem = (rem<<2) | next 2 radicand bits; trial = (root<<2)|1.
//    If rem >= trial then rem -= trial and root = (root<<1)|1; else root = root<<1.
//    Each stage is registered. The radicand is zero-extended to 2*ROOT_W bits.
//  - Latency: exactly ROOT_W cycles from accepted input to o_valid when no stall occurs.
//    Throughput is 1 result per cycle.
//  - Stall: stall = o_valid & ~o_ready. While stalled, every stage register and valid bit holds.
//    i_ready = ~stall. Stall is combinational from o_ready (no skid buffer).
//  - Bubbles are not collapsed. An empty output slot never causes a stall.
//  - Accept: i_valid & i_ready. If i_valid & ~i_ready, the input is dropped and o_overflow sets.
//    o_overflow is cleared only by reset.
//    The upstream adder tree has no ready input. The top level ties o_ready=1 or monitors o_overflow.
//  - Outputs hold stable while o_valid & ~o_ready (AXI-style: no change until the transfer completes).
//  - Boundaries:
//    i_data=0 gives root 0, rem 0.
//    i_data=all-ones gives root 2^ROOT_W-1, rem 2^(ROOT_W+1)-2.
//    Simultaneous output handshake and input accept in the same cycle is legal; the pipeline advances.
// CONFIGURATION
//  VECTOR_NORM_ROUND_EN defined:
//    o_root = floor_root + (rem > floor_root), i.e. round-to-nearest.
//    The result saturates at 2^ROOT_W-1 (the all-ones radicand case).
//    The +1 is applied in the last stage's register; latency is unchanged.
//  VECTOR_NORM_ROUND_EN not defined:
//    o_root = floor_root. No extra logic.
//  o_rem is the floor remainder in both modes.
// STRUCTURE
//  - Package vector_norm_pkg holds:
//    ROOT_W/REM_W functions of DATAWIDTH.
//    typedef struct packed {valid, rem, root, radicand_tail} sqrt_stage_t.
//  - Sub-module sqrt_stage: one digit step (combinational trial/subtract + register with hold enable).
//    Instantiated ROOT_W times via generate.
//  - Top holds only stall/ready logic, o_overflow and the optional rounding.
// TESTING (DATAWIDTH=4, ROOT_W=5)
//  1. Reset, then i_data=900, o_ready=1 -> o_valid 5 cycles later, root 30, rem 0; o_overflow=0.
//  2. Stream 0,10,12,13,1023 back-to-back, o_ready=1 -> consecutive results:
//     floor mode: (0,0) (3,1) (3,3) (3,4) (31,62).
//     ROUND_EN: roots 0,3,3,4,31 (31 is the saturated case).
//  3. Fill pipeline, drop o_ready for 3 cycles -> outputs stable; i_ready=0 during the stall.
//     Resume -> no loss, no duplicate, order preserved.
//  4. i_valid=1 while stalled -> o_overflow=1 and remains set; that sample never appears at the output.
//  5. Assert rst mid-stream with 3 items in flight -> o_valid=0 asynchronously.
//     After release, a new input 49 yields root 7, rem 0 after 5 cycles.
//  6. Random radicands 0..1023 vs reference model (root^2+rem==x, rem<=2*root), both macro settings.

Source files
------------

// File: rtl/vector_norm_pkg.sv
// Shared types and sizing for the vector-magnitude square-root pipeline.
// ROOT_W / REM_W are derived from the upstream element width (NORM_DATAWIDTH).
package vector_norm_pkg;

    localparam int NORM_DATAWIDTH = 4;

    // Root width equals the number of pipeline stages (one root bit per stage).
    function automatic int root_w(input int dw);
        return dw + 1;
    endfunction

    // Remainder never exceeds 2*root, so one bit more than the root suffices.
    function automatic int rem_w(input int dw);
        return dw + 2;
    endfunction

    localparam int ROOT_W = root_w(NORM_DATAWIDTH);
    localparam int REM_W  = rem_w(NORM_DATAWIDTH);
    localparam int RAD_W  = 2 * ROOT_W;

    // State carried between digit stages; radicand_tail is consumed two bits
    // at a time from its MSB end.
    typedef struct packed {
        logic              valid;
        logic [REM_W-1:0]  rem;
        logic [ROOT_W-1:0] root;
        logic [RAD_W-1:0]  radicand_tail;
    } sqrt_stage_t;

endpackage

// File: rtl/vector_norm_sqrt_stage.sv
// One restoring square-root digit step: brings in the next two radicand bits,
// tries (root<<2)|1 against the partial remainder and resolves one root bit.
// The result is registered; the register holds when en is low.
// With ROUND_OUT set (last stage only) the registered root is rounded to
// nearest and saturated, while the remainder stays the floor remainder.
module sqrt_stage
    import vector_norm_pkg::*;
#(
    parameter bit ROUND_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  sqrt_stage_t stage_i,
    output sqrt_stage_t stage_o
);

    logic [REM_W+1:0]  rem_shift;
    logic [ROOT_W+1:0] trial;
    logic              take;
    logic [REM_W-1:0]  rem_new;
    logic [ROOT_W-1:0] root_floor;
    logic [ROOT_W:0]   root_inc;
    sqrt_stage_t       step_s;
    sqrt_stage_t       stage_d;
    sqrt_stage_t       stage_q;

    // Trial subtraction for this digit. The difference always fits in REM_W
    // bits, so the subtract is done at that width.
    always_comb begin
        rem_shift  = {stage_i.rem, stage_i.radicand_tail[RAD_W-1 -: 2]};
        trial      = {stage_i.root, 2'b01};
        take       = (rem_shift >= {1'b0, trial});
        rem_new    = take ? (rem_shift[REM_W-1:0] - trial[REM_W-1:0])
                          : rem_shift[REM_W-1:0];
        root_floor = {stage_i.root[ROOT_W-2:0], take};
        root_inc   = {1'b0, root_floor}
                   + {{ROOT_W{1'b0}}, (rem_new > {1'b0, root_floor})};

        step_s               = stage_i;
        step_s.rem           = rem_new;
        step_s.root          = root_floor;
        step_s.radicand_tail = {stage_i.radicand_tail[RAD_W-3:0], 2'b00};
        if (ROUND_OUT) begin
            step_s.root = root_inc[ROOT_W] ? {ROOT_W{1'b1}} : root_inc[ROOT_W-1:0];
        end
    end

    // Advance when the pipeline moves, otherwise hold.
    always_comb begin
        stage_d = en ? step_s : stage_q;
    end

    // Stage register; reset discards whatever was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/vector_norm_sqrt.sv
// Vector magnitude: floor integer square root (plus remainder) of the
// sum-of-squares produced by the upstream multiply/adder tree.
// Fully pipelined, ROOT_W stages, one result per cycle, backpressure via o_ready.
// Optional macro VECTOR_NORM_ROUND_EN: o_root rounded to nearest (saturating);
// o_rem is always the floor remainder.
module vector_norm_sqrt
    import vector_norm_pkg::*;
#(
    parameter  int DATAWIDTH   = NORM_DATAWIDTH,
    parameter  int INSTANCE_ID = 0,
    localparam int IN_W        = 2 * DATAWIDTH + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [IN_W-1:0]   i_data,
    output logic              i_ready,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ROOT_W-1:0] o_root,
    output logic [REM_W-1:0]  o_rem,
    output logic              o_overflow
);

`ifdef VECTOR_NORM_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    // The stage struct is sized from the package; other widths are not supported.
    if (DATAWIDTH != NORM_DATAWIDTH) begin : g_bad_cfg
        $error("vector_norm_sqrt: DATAWIDTH must equal vector_norm_pkg::NORM_DATAWIDTH");
    end

    logic        stall;
    logic        overflow_d;
    logic        overflow_q;
    sqrt_stage_t head_s;
    sqrt_stage_t stage_in  [ROOT_W];
    sqrt_stage_t stage_out [ROOT_W];

    // Whole pipeline freezes only when a valid result is waiting; bubbles
    // at the output never hold anything back.
    assign stall   = o_valid & ~o_ready;
    assign i_ready = ~stall;

    // Fresh radicand entering the first digit stage.
    always_comb begin
        head_s               = '0;
        head_s.valid         = i_valid;
        head_s.radicand_tail = RAD_W'(i_data);
    end

    for (genvar gi = 0; gi < ROOT_W; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_in[gi] = head_s;
        end else begin : g_link
            assign stage_in[gi] = stage_out[gi-1];
        end

        sqrt_stage #(
            .ROUND_OUT (ROUND_EN && (gi == ROOT_W - 1))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (~stall),
            .stage_i (stage_in[gi]),
            .stage_o (stage_out[gi])
        );
    end

    assign o_valid = stage_out[ROOT_W-1].valid;
    assign o_root  = stage_out[ROOT_W-1].root;
    assign o_rem   = stage_out[ROOT_W-1].rem;

    // Sticky flag: a sample offered while the pipeline was stalled was lost.
    always_comb begin
        overflow_d = overflow_q | (i_valid & ~i_ready);
    end

    // Overflow register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_vector_norm_sqrt.sv
// Self-checking bench for vector_norm_sqrt (DATAWIDTH=4). Works with and
// without VECTOR_NORM_ROUND_EN defined.
module tb_vector_norm_sqrt;

`ifdef VECTOR_NORM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic [9:0] i_data = '0;
    logic       i_ready;
    logic       o_valid;
    logic       o_ready = 1'b1;
    logic [4:0] o_root;
    logic [5:0] o_rem;
    logic       o_overflow;

    vector_norm_sqrt #(
        .DATAWIDTH   (4),
        .INSTANCE_ID (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_root     (o_root),
        .o_rem      (o_rem),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [4:0] root_floor;
        logic [4:0] root_round;
        logic [5:0] rem;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic [4:0] root;
        logic [5:0] rem;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_out = 0;
    logic [4:0] drv_root = '0;
    logic [5:0] drv_rem = '0;
    logic       stall_prev = 1'b0;
    logic [4:0] prev_root = '0;
    logic [5:0] prev_rem = '0;
    vec_t       tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exhaustive search for the largest r with r*r <= x.
    function automatic int ref_floor(input int x);
        for (int r = 31; r > 0; r--) begin
            if (r * r <= x) return r;
        end
        return 0;
    endfunction

    function automatic int ref_root(input int x);
        int f;
        int m;
        f = ref_floor(x);
        m = x - f * f;
        if (RND && (m > f) && (f < 31)) return f + 1;
        return f;
    endfunction

    function automatic int ref_rem(input int x);
        int f;
        f = ref_floor(x);
        return x - f * f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int r, input int m);
        i_valid  = 1'b1;
        i_data   = x[9:0];
        drv_root = r[4:0];
        drv_rem  = m[5:0];
        step();
    endtask

    task automatic drive_model(input int x);
        drive(x, ref_root(x), ref_rem(x));
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    // Returns number of cycles since acceptance until o_valid (bounded).
    task automatic measure_latency(output int lat);
        lat = 1;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Scoreboard: push on accept, pop/compare on output handshake, and
    // check that outputs hold while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", o_valid, 1);
                check("stall_hold_root", o_root, prev_root);
                check("stall_hold_rem", o_rem, prev_rem);
            end
            if (i_valid && i_ready) begin
                sb.push_back('{x: i_data, root: drv_root, rem: drv_rem});
            end
            if (o_valid && o_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output_root", o_root, -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out x=%0d root=%0d rem=%0d (exp %0d,%0d)",
                             e.x, o_root, o_rem, e.root, e.rem);
                    check("out_root", o_root, e.root);
                    check("out_rem", o_rem, e.rem);
                end
            end
            stall_prev = o_valid && !o_ready;
            prev_root  = o_root;
            prev_rem   = o_rem;
        end
    end

    initial begin
        int lat;
        int run;
        int out0;
        logic [4:0] hold_root;
        logic [5:0] hold_rem;

        tbl[0] = '{x: 10'd900,  root_floor: 5'd30, root_round: 5'd30, rem: 6'd0};
        tbl[1] = '{x: 10'd0,    root_floor: 5'd0,  root_round: 5'd0,  rem: 6'd0};
        tbl[2] = '{x: 10'd10,   root_floor: 5'd3,  root_round: 5'd3,  rem: 6'd1};
        tbl[3] = '{x: 10'd12,   root_floor: 5'd3,  root_round: 5'd3,  rem: 6'd3};
        tbl[4] = '{x: 10'd13,   root_floor: 5'd3,  root_round: 5'd4,  rem: 6'd4};
        tbl[5] = '{x: 10'd1023, root_floor: 5'd31, root_round: 5'd31, rem: 6'd62};
        tbl[6] = '{x: 10'd49,   root_floor: 5'd7,  root_round: 5'd7,  rem: 6'd0};

        // 1. Reset state, then a single radicand and its latency.
        step();
        check("reset_o_valid", o_valid, 0);
        check("reset_o_root", o_root, 0);
        check("reset_o_rem", o_rem, 0);
        check("reset_o_overflow", o_overflow, 0);
        check("reset_i_ready", i_ready, 1);
        step();
        rst = 1'b1;
        step();
        drive(tbl[0].x, RND ? tbl[0].root_round : tbl[0].root_floor, tbl[0].rem);
        i_valid = 1'b0;
        measure_latency(lat);
        check("latency_900", lat, 5);
        check("overflow_after_900", o_overflow, 0);
        idle(3);

        // 2. Back-to-back stream from the table; five consecutive results.
        out0 = n_out;
        for (int k = 1; k <= 5; k++) begin
            drive(tbl[k].x, RND ? tbl[k].root_round : tbl[k].root_floor, tbl[k].rem);
        end
        i_valid = 1'b0;
        run = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_valid) run++;
            step();
        end
        check("stream_consecutive_valid", run, 5);
        check("stream_drained_valid", o_valid, 0);
        idle(2);
        check("stream_result_count", n_out - out0, 5);

        // 3. Fill, stall three cycles, resume.
        out0 = n_out;
        for (int k = 0; k < 5; k++) drive_model(100 + 111 * k);
        i_valid = 1'b0;
        o_ready = 1'b0;
        hold_root = o_root;
        hold_rem  = o_rem;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall3_i_ready", i_ready, 0);
            check("stall3_root", o_root, hold_root);
            check("stall3_rem", o_rem, hold_rem);
        end
        o_ready = 1'b1;
        idle(8);
        check("stall3_result_count", n_out - out0, 5);
        check("stall3_sb_empty", sb.size(), 0);
        check("stall3_no_overflow", o_overflow, 0);

        // 4. Input offered during a stall is dropped and flags overflow.
        out0 = n_out;
        for (int k = 0; k < 3; k++) drive_model(500 + 7 * k);
        i_valid = 1'b0;
        measure_latency(lat);
        check("ovf_wait_valid", o_valid, 1);
        o_ready = 1'b0;
        #1;
        drive(77, 0, 0);
        i_valid = 1'b0;
        check("ovf_set", o_overflow, 1);
        o_ready = 1'b1;
        idle(10);
        check("ovf_sticky", o_overflow, 1);
        check("ovf_result_count", n_out - out0, 3);

        // 5. Asynchronous reset with data in flight, then recovery.
        for (int k = 0; k < 5; k++) drive_model(3 + 41 * k);
        i_valid = 1'b0;
        check("rst_pre_valid", o_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_valid", o_valid, 0);
        check("rst_async_root", o_root, 0);
        check("rst_async_rem", o_rem, 0);
        check("rst_async_overflow", o_overflow, 0);
        sb.delete();
        step();
        step();
        rst = 1'b1;
        step();
        drive(tbl[6].x, RND ? tbl[6].root_round : tbl[6].root_floor, tbl[6].rem);
        i_valid = 1'b0;
        measure_latency(lat);
        check("rst_latency_49", lat, 5);
        idle(4);

        // 6. Random radicands with random backpressure and input gaps.
        for (int k = 0; k < 400; k++) begin
            int x;
            x = $urandom_range(0, 1023);
            o_ready  = ($urandom_range(0, 3) != 0);
            i_valid  = ($urandom_range(0, 3) != 0);
            i_data   = x[9:0];
            drv_root = ref_root(x);
            drv_rem  = ref_rem(x);
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        idle(10);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
